// File: rtl/bicubic_pixel_pack.sv
// Back end of the bicubic datapath: rounds, rescales and clamps sign-magnitude
// products to 8 bits, then packs R, G, B beats into one buffered 24-bit pixel.
module bicubic_pixel_pack #(
   parameter int PRODUCT_WIDTH = 32,
   parameter int FRAC_BITS     = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [PRODUCT_WIDTH-2:0] s_product,
   input  logic                     s_product_sign,
   input  logic                     s_last,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [23:0]              m_pixel,
   output logic                     m_last,
   output logic [15:0]              clamp_cnt,
   input  logic                     clamp_cnt_clr
);

   localparam logic [PRODUCT_WIDTH-1:0] HALF_LSB = PRODUCT_WIDTH'(1) << (FRAC_BITS - 1);

   logic [1:0]  ch_q, ch_d;
   logic [7:0]  r_hold_q, r_hold_d;
   logic [7:0]  g_hold_q, g_hold_d;
   logic [23:0] pixel_q, pixel_d;
   logic        last_q, last_d;
   logic        valid_q, valid_d;
   logic [15:0] clamp_cnt_q, clamp_cnt_d;

   logic                     accept;
   logic [PRODUCT_WIDTH-1:0] rounded;
   logic [PRODUCT_WIDTH-1:0] scaled;
   logic [7:0]               conv;
   logic                     clamp;

   assign s_ready = (ch_q != 2'd2) || !valid_q || m_ready;
   assign accept  = s_valid && s_ready;

   // Rounding add is one bit wider than the magnitude so the carry survives.
   always_comb begin
      rounded = {1'b0, s_product} + HALF_LSB;
      scaled  = rounded >> FRAC_BITS;
      conv    = scaled[7:0];
      clamp   = 1'b0;
      if (s_product_sign) begin
         conv  = 8'd0;
         clamp = |s_product;
      end else if (|scaled[PRODUCT_WIDTH-1:8]) begin
         conv  = 8'hFF;
         clamp = 1'b1;
      end
   end

   always_comb begin
      ch_d        = ch_q;
      r_hold_d    = r_hold_q;
      g_hold_d    = g_hold_q;
      pixel_d     = pixel_q;
      last_d      = last_q;
      valid_d     = valid_q;
      clamp_cnt_d = clamp_cnt_q;

      if (valid_q && m_ready) begin
         valid_d = 1'b0;
      end

      if (accept) begin
         case (ch_q)
            2'd0: begin
               r_hold_d = conv;
               ch_d     = 2'd1;
            end
            2'd1: begin
               g_hold_d = conv;
               ch_d     = 2'd2;
            end
            default: begin
               pixel_d = {r_hold_q, g_hold_q, conv};
               last_d  = s_last;
               valid_d = 1'b1;
               ch_d    = 2'd0;
            end
         endcase
      end

      // Clear wins over a same-cycle clamp.
      if (clamp_cnt_clr) begin
         clamp_cnt_d = 16'd0;
      end else if (accept && clamp && (clamp_cnt_q != 16'hFFFF)) begin
         clamp_cnt_d = clamp_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_q        <= 2'd0;
         r_hold_q    <= 8'd0;
         g_hold_q    <= 8'd0;
         pixel_q     <= 24'd0;
         last_q      <= 1'b0;
         valid_q     <= 1'b0;
         clamp_cnt_q <= 16'd0;
      end else begin
         ch_q        <= ch_d;
         r_hold_q    <= r_hold_d;
         g_hold_q    <= g_hold_d;
         pixel_q     <= pixel_d;
         last_q      <= last_d;
         valid_q     <= valid_d;
         clamp_cnt_q <= clamp_cnt_d;
      end
   end

   assign m_valid   = valid_q;
   assign m_pixel   = pixel_q;
   assign m_last    = last_q;
   assign clamp_cnt = clamp_cnt_q;

endmodule

// File: tb/tb_bicubic_pixel_pack.sv
// Bench for bicubic_pixel_pack: directed scenarios plus randomized traffic, checked
// against a queue-based model of channel collection, output buffer and clamp counter.
module tb_bicubic_pixel_pack;

   localparam int PW = 32;
   localparam int FB = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [PW-2:0] s_product = '0;
   logic          s_product_sign = 1'b0;
   logic          s_last = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [23:0]   m_pixel;
   logic          m_last;
   logic [15:0]   clamp_cnt;
   logic          clamp_cnt_clr = 1'b0;

   bicubic_pixel_pack #(.PRODUCT_WIDTH(PW), .FRAC_BITS(FB)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_product      (s_product),
      .s_product_sign (s_product_sign),
      .s_last         (s_last),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_pixel        (m_pixel),
      .m_last         (m_last),
      .clamp_cnt      (clamp_cnt),
      .clamp_cnt_clr  (clamp_cnt_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] pix;
      logic        last;
   } px_t;

   int          checks = 0;
   int          errors = 0;
   int          n_xfer = 0;
   bit          last_acc;
   byte unsigned pend[$];
   px_t         outq[$];
   int          exp_cnt = 0;

   // Reference conversion in plain integer arithmetic.
   function automatic int ref_conv(input longint mag, input bit sg);
      longint r;
      if (sg) return 0;
      r = (mag + (64'd1 << (FB - 1))) / (64'd1 << FB);
      return (r > 255) ? 255 : int'(r);
   endfunction

   function automatic bit ref_clamp(input longint mag, input bit sg);
      if (sg) return mag != 0;
      return ((mag + (64'd1 << (FB - 1))) / (64'd1 << FB)) > 255;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Called at a falling edge with inputs already driven; checks, clocks, updates model.
   task automatic tick();
      bit exp_ready, acc, xfer;
      #1;
      exp_ready = !(pend.size() == 2 && outq.size() > 0 && !m_ready);
      chk("s_ready", s_ready, exp_ready);
      chk("m_valid", m_valid, outq.size() > 0);
      if (outq.size() > 0) begin
         chk("m_pixel", m_pixel, outq[0].pix);
         chk("m_last", m_last, outq[0].last);
      end
      chk("clamp_cnt", clamp_cnt, exp_cnt);
      acc  = s_valid && exp_ready;
      xfer = (outq.size() > 0) && m_ready;
      last_acc = acc;
      @(posedge clk);
      if (xfer) begin
         void'(outq.pop_front());
         n_xfer++;
      end
      if (acc) begin
         pend.push_back(byte'(ref_conv(s_product, s_product_sign)));
         if (pend.size() == 3) begin
            outq.push_back('{pix: {pend[0], pend[1], pend[2]}, last: s_last});
            pend.delete();
         end
      end
      if (clamp_cnt_clr) exp_cnt = 0;
      else if (acc && ref_clamp(s_product, s_product_sign) && exp_cnt != 16'hFFFF) exp_cnt++;
      @(negedge clk);
   endtask

   task automatic send(input logic [PW-2:0] mag, input bit sg, input bit lst);
      s_valid = 1'b1;
      s_product = mag;
      s_product_sign = sg;
      s_last = lst;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (last_acc) break;
      end
      if (!last_acc) chk("accept_timeout", 32'(last_acc), 32'd1);
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [PW-2:0] rand_mag();
      case ($urandom % 5)
         0: return (PW-1)'($urandom % 20000);
         1: return (PW-1)'(16350 + ($urandom % 4));
         2: return '1;
         3: return '0;
         default: return (PW-1)'($urandom);
      endcase
   endfunction

   initial begin
      int base;
      // Reset state
      #2;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_pixel", m_pixel, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_clamp_cnt", clamp_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1. Basic pack
      m_ready = 1'b1;
      send(4096, 0, 0);
      send(95, 0, 0);
      send(96, 0, 1);
      chk("basic_valid", m_valid, 1);
      chk("basic_pixel", m_pixel, 24'h400102);
      chk("basic_last", m_last, 1);
      idle(1);
      chk("basic_one_cycle", m_valid, 0);
      chk("basic_cnt", clamp_cnt, 0);

      // 2. Clamping
      send(5, 1, 0);
      send(31'h7FFFFFFF, 0, 0);
      send(0, 1, 0);
      chk("clamp_pixel", m_pixel, 24'h00FF00);
      idle(1);
      chk("clamp_cnt2", clamp_cnt, 2);

      // 3. Backpressure
      m_ready = 1'b0;
      base = n_xfer;
      send(100, 0, 0); send(200, 0, 0); send(300, 0, 1);
      send(400, 0, 0); send(500, 0, 0);
      s_product = 600; s_product_sign = 0; s_last = 0; s_valid = 1'b1;
      tick(); tick();
      chk("bp_stall_accept", 32'(last_acc), 0);
      chk("bp_hold_pixel", m_pixel, {8'(ref_conv(100,0)), 8'(ref_conv(200,0)), 8'(ref_conv(300,0))});
      m_ready = 1'b1;
      tick();
      chk("bp_b_accepted", 32'(last_acc), 1);
      chk("bp_second_pixel", m_pixel, {8'(ref_conv(400,0)), 8'(ref_conv(500,0)), 8'(ref_conv(600,0))});
      idle(3);
      chk("bp_xfer_count", n_xfer - base, 2);

      // 4. Streaming
      base = n_xfer;
      for (int i = 0; i < 30; i++) send(rand_mag(), ($urandom % 4) == 0, $urandom % 2);
      idle(2);
      chk("stream_xfer_count", n_xfer - base, 10);

      // 5. Reset mid-operation
      send(1000, 0, 0);
      send(2000, 0, 0);
      s_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_m_valid", m_valid, 0);
      chk("arst_m_pixel", m_pixel, 0);
      chk("arst_m_last", m_last, 0);
      chk("arst_cnt", clamp_cnt, 0);
      chk("arst_s_ready", s_ready, 1);
      pend.delete(); outq.delete(); exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      send(64, 0, 0); send(128, 0, 0); send(192, 0, 1);
      chk("arst_pixel", m_pixel, 24'h010203);
      idle(1);

      // Randomized traffic with random backpressure and occasional clears
      for (int i = 0; i < 400; i++) begin
         s_valid = ($urandom % 4) != 0;
         m_ready = ($urandom % 3) != 0;
         clamp_cnt_clr = ($urandom % 40) == 0;
         s_product = rand_mag();
         s_product_sign = ($urandom % 4) == 0;
         s_last = $urandom % 2;
         tick();
      end
      clamp_cnt_clr = 1'b0;
      m_ready = 1'b1;
      idle(3);
      // Finish any partial pixel so the counter test starts on an R beat
      while (pend.size() != 0) send(0, 0, 0);

      // 6. Counter edges
      clamp_cnt_clr = 1'b1;
      idle(1);
      clamp_cnt_clr = 1'b0;
      for (int i = 0; i < 65535; i++) send(1, 1, 0);
      chk("cnt_at_max", clamp_cnt, 16'hFFFF);
      send(31'h7FFFFFFF, 0, 0);
      chk("cnt_saturated", clamp_cnt, 16'hFFFF);
      clamp_cnt_clr = 1'b1;
      send(7, 1, 0);
      clamp_cnt_clr = 1'b0;
      chk("cnt_clr_priority", clamp_cnt, 0);
      send(16352, 0, 1);
      chk("cnt_after_clr", clamp_cnt, 1);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
